ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

Execute-to-writeback stage placed directly downstream of the 16-bit ALU. It captures each ALU result and its flags (`Negative`, `Zero`, `Carry`, `OverFlow`) with the destination register tag. Captured entries are held in a small in-order buffer with valid/ready handshakes on both sides. On commit, the stage presents each entry to the register-file write port, updates the architectural NZCV status register, and provides result forwarding for in-flight entries.

## Interface
Parameters:
- `DATA_W`, 16, result width; must match the ALU.
- `ADDR_W`, 3, register-tag width.
- `DEPTH`, 2, buffer entries; legal values are 2 and 4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU output is valid this cycle.
- `in_ready`  out  1  stage can accept an entry.
- `in_result`  in  DATA_W  ALU `Result`.
- `in_flags`  in  4  {N,Z,C,V}, taken from ALU `Negative`, `Zero`, `Carry`, `OverFlow`.
- `in_rd`  in  ADDR_W  destination register.
- `in_wr_en`  in  1  entry writes the register file.
- `in_set_flags`  in  1  entry updates NZCV on commit.
- `flush`  in  1  discard all buffered entries.
- `out_valid`  out  1  head entry is presented.
- `out_ready`  in  1  register file accepts the head entry.
- `out_result`  out  DATA_W  head result.
- `out_rd`  out  ADDR_W  head destination.
- `out_wr_en`  out  1  head write enable; qualified by `out_valid`.
- `flags_q`  out  4  architectural NZCV, ordered {N,Z,C,V}.
- `fwd_addr`  in  ADDR_W  register being looked up.
- `fwd_hit`  out  1  a buffered entry with `wr_en`=1 targets `fwd_addr`.
- `fwd_data`  out  DATA_W  result of the youngest matching entry; 0 when there is no hit.

## Operation
- **Storage:** in-order FIFO of DEPTH entries, each holding {result, flags, rd, wr_en, set_flags}. Read and write pointers wrap modulo DEPTH. An occupancy count runs from 0 to DEPTH.
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (count != DEPTH)`.
  - `in_ready` does not depend on `out_ready`, so a full buffer never accepts an entry, even in a pop cycle.
- **Pop (commit):** occurs when `out_valid && out_ready`. `out_valid = (count != 0)`. The `out_*` ports show the head entry combinationally from storage.
- **Simultaneous push and pop:** allowed when 0 < count < DEPTH. The count is unchanged and both pointers advance.
- **NZCV update:** on a pop whose head has `set_flags`=1, `flags_q` takes the head's flags at that edge. Otherwise `flags_q` holds.
  - Flags never update at push time, only at commit.
- **Flush:** synchronous. At the edge, count becomes 0 and both pointers reset to 0.
  - Flush overrides a push and a pop in the same cycle; the popped entry does not update NZCV.
  - `flags_q` itself is never cleared by flush.
- **Forwarding:** purely combinational. The stage scans all valid entries. Where several entries match, the youngest (nearest the write pointer) wins. Register 0 is not special.
  - A same-cycle push is not visible to forwarding until the next cycle.
- **Reset:** count 0, pointers 0, `flags_q` 4'b0000.
  - Outputs after reset: `out_valid`=0, `in_ready`=1, `fwd_hit`=0, `fwd_data`=0.
  - Entry storage needs no reset; it is never observable while its entry is invalid.
- **Mid-operation reset:** asserting `rst_n` low discards the buffer contents immediately (asynchronously).

## Timing
- Latency from push to earliest presentation is 1 cycle: an entry pushed at edge k is on `out_*` after edge k, and can commit at edge k+1.
- Throughput is 1 entry/cycle while the buffer is neither empty nor full and `out_ready`=1. A full buffer with a pop still loses one cycle of input, by design.
- `in_ready` and `out_valid` are decoded from registered count only, with no input-to-output combinational path.
- The forwarding paths (`fwd_addr` to `fwd_hit`/`fwd_data`) are combinational.
- NZCV is visible on `flags_q` the cycle after its commit edge.

## Structure
- **Shared package `ex_wb_pkg`:**
  - Flag index constants: N=3, Z=2, C=1, V=0.
  - The `ex_wb_entry_t` struct.
  - The `FLAGS_W`=4 constant.
- **Sub-module `ex_wb_fifo`:** storage, pointers, count and flush; it exposes all entries and a valid mask for the forwarding scan.
- **Top level:** the NZCV register, the forward priority mux and the handshake decode.

## Test plan
- **Reset:** hold `rst_n` low, release it, then idle → `in_ready`=1, `out_valid`=0, `flags_q`=0000, `fwd_hit`=0.
- **Single entry:** push {result 0x8000, flags 1000, rd 5, wr_en 1, set_flags 1} with `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_result`=0x8000, `flags_q` still 0000.
  - Raise `out_ready`: `flags_q`=1000 the cycle after the commit edge.
- **Fill and back-pressure:** with `out_ready`=0, push 0x0001 then 0x0002 → `in_ready`=0.
  - A third `in_valid` with 0x0003 is not accepted.
  - Drain → pops 0x0001 then 0x0002, in order.
- **Forwarding priority:** buffer holds rd 3=0x1111 (older) and rd 3=0x2222 (younger), with `fwd_addr`=3 → `fwd_hit`=1, `fwd_data`=0x2222.
  - An entry with `wr_en`=0 targeting rd 3 → ignored.
- **Flush vs commit:** with one entry (set_flags 1, flags 0100) and `flush`=1, `out_ready`=1 in the same cycle → count 0, `flags_q` unchanged.
- **Streaming and mid-stream reset:** stream 8 entries with `in_valid`/`out_ready` both held high → 1 commit/cycle after the first.
  - Assert `rst_n` low mid-stream → `out_valid` drops immediately and `flags_q`=0000.

Source files
------------

// File: rtl/ex_wb_pkg.sv
// Shared types and constants for the execute-to-writeback stage.
// Entry field widths are tied to the 16-bit ALU and its 3-bit register tags.
package ex_wb_pkg;

    localparam int FLAGS_W      = 4;
    localparam int FLAG_N       = 3;
    localparam int FLAG_Z       = 2;
    localparam int FLAG_C       = 1;
    localparam int FLAG_V       = 0;
    localparam int ENTRY_DATA_W = 16;
    localparam int ENTRY_ADDR_W = 3;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] result;
        logic [FLAGS_W-1:0]      flags;
        logic [ENTRY_ADDR_W-1:0] rd;
        logic                    wr_en;
        logic                    set_flags;
    } ex_wb_entry_t;

endpackage

// File: rtl/ex_wb_fifo.sv
// In-order entry buffer: storage, wrapping pointers, occupancy count and flush.
// All slots and a per-slot valid mask are exposed for the forwarding scan.
module ex_wb_fifo
    import ex_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  ex_wb_entry_t                wdata_i,
    output ex_wb_entry_t [DEPTH-1:0]    entries_o,
    output logic [DEPTH-1:0]            valid_o,
    output logic [PTR_W-1:0]            rd_ptr_o,
    output logic [CNT_W-1:0]            count_o
);

    ex_wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         age;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; a slot is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        age     = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age        = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, age} < count_q);
        end
    end

    assign entries_o = mem_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results, commits them to the register
// file, maintains architectural NZCV and forwards in-flight results.
module ex_wb_stage
    import ex_wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [FLAGS_W-1:0] in_flags,
    input  logic [ADDR_W-1:0]  in_rd,
    input  logic               in_wr_en,
    input  logic               in_set_flags,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [ADDR_W-1:0]  out_rd,
    output logic               out_wr_en,
    output logic [FLAGS_W-1:0] flags_q,
    input  logic [ADDR_W-1:0]  fwd_addr,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ex_wb_entry_t [DEPTH-1:0] entries;
    ex_wb_entry_t             wdata;
    ex_wb_entry_t             head;
    logic [DEPTH-1:0]         valid;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [PTR_W-1:0]         slot;
    logic [FLAGS_W-1:0]       flags_d;
    logic                     push;
    logic                     pop;

    // Handshakes decode from the registered count only; a full buffer refuses
    // input even while it is being popped.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wdata = '{result: in_result, flags: in_flags, rd: in_rd,
                     wr_en: in_wr_en, set_flags: in_set_flags};

    ex_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (flush),
        .wdata_i   (wdata),
        .entries_o (entries),
        .valid_o   (valid),
        .rd_ptr_o  (rd_ptr),
        .count_o   (count)
    );

    assign head       = entries[rd_ptr];
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wr_en  = head.wr_en;

    // A flushed commit never reaches the architectural flags.
    always_comb begin
        flags_d = flags_q;
        if (pop && !flush && head.set_flags) begin
            flags_d[FLAG_N] = head.flags[FLAG_N];
            flags_d[FLAG_Z] = head.flags[FLAG_Z];
            flags_d[FLAG_C] = head.flags[FLAG_C];
            flags_d[FLAG_V] = head.flags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int a = 0; a < DEPTH; a++) begin
            slot = rd_ptr + PTR_W'(a);
            if (valid[slot] && entries[slot].wr_en && entries[slot].rd == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[slot].result;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage (DEPTH=2).
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic [2:0]  in_rd;
    logic        in_wr_en;
    logic        in_set_flags;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wr_en;
    logic [3:0]  flags_q;
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    int total = 0;
    int bad   = 0;

    ex_wb_stage #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .in_set_flags (in_set_flags),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wr_en    (out_wr_en),
        .flags_q      (flags_q),
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] r, input logic [3:0] f,
                          input logic [2:0] rd, input logic we, input logic sf);
        in_valid     = v;
        in_result    = r;
        in_flags     = f;
        in_rd        = rd;
        in_wr_en     = we;
        in_set_flags = sf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        flush = 1'b0; out_ready = 1'b0; fwd_addr = 3'd0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%b exp=0", fwd_hit); end
        total++; if (fwd_data !== 16'h0) begin bad++; $display("FAIL reset_fwd_data got=%h exp=0000", fwd_data); end
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        set_in(1'b1, 16'h8000, 4'b1000, 3'd5, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        fwd_addr = 3'd5;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        total++; if (out_result !== 16'h8000) begin bad++; $display("FAIL single_out_result got=%h exp=8000", out_result); end
        total++; if (out_rd !== 3'd5 || out_wr_en !== 1'b1) begin bad++; $display("FAIL single_out_rd got=%0d/%b exp=5/1", out_rd, out_wr_en); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL single_flags_before got=%b exp=0000", flags_q); end
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h8000) begin bad++; $display("FAIL single_fwd got=%b/%h exp=1/8000", fwd_hit, fwd_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL single_flags_after got=%b exp=1000", flags_q); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        set_in(1'b1, 16'h0001, 4'b0000, 3'd1, 1'b1, 1'b0);
        step();
        set_in(1'b1, 16'h0002, 4'b0000, 3'd2, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        set_in(1'b1, 16'h0003, 4'b0000, 3'd3, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        total++; if (out_result !== 16'h0001) begin bad++; $display("FAIL fill_pop0 got=%h exp=0001", out_result); end
        step();
        total++; if (out_valid !== 1'b1 || out_result !== 16'h0002) begin bad++; $display("FAIL fill_pop1 got=%b/%h exp=1/0002", out_valid, out_result); end
        step();
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_third_dropped got=%b exp=0", out_valid); end
        total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL fill_flags_hold got=%b exp=1000", flags_q); end
    endtask

    task automatic test_forward();
        out_ready = 1'b0;
        set_in(1'b1, 16'h1111, 4'b0000, 3'd3, 1'b1, 1'b0);
        step();
        set_in(1'b1, 16'h2222, 4'b0000, 3'd3, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        fwd_addr = 3'd3;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h2222) begin bad++; $display("FAIL fwd_youngest got=%b/%h exp=1/2222", fwd_hit, fwd_data); end
        fwd_addr = 3'd4;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_in(1'b1, 16'h3333, 4'b0000, 3'd3, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        fwd_addr = 3'd3;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h2222) begin bad++; $display("FAIL fwd_wr_en0 got=%b/%h exp=1/2222", fwd_hit, fwd_data); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fwd_flush got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        fwd_addr  = 3'd2;
        set_in(1'b1, 16'h0000, 4'b0100, 3'd2, 1'b1, 1'b1);
        #1;
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL flush_fwd_samecycle got=%b exp=0", fwd_hit); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0) begin bad++; $display("FAIL flush_fwd_next got=%b/%h exp=1/0000", fwd_hit, fwd_data); end
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_count got=%b/%b exp=0/1", out_valid, in_ready); end
        total++; if (flags_q !== 4'b1000) begin bad++; $display("FAIL flush_flags got=%b exp=1000", flags_q); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_r;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 16'h0010 + 16'(i), 4'(i), 3'(i), 1'b1, 1'b1);
            #1;
            if (i > 0) begin
                exp_r = 16'h0010 + 16'(i - 1);
                total++; if (out_valid !== 1'b1 || out_result !== exp_r) begin bad++; $display("FAIL stream_head%0d got=%b/%h exp=1/%h", i, out_valid, out_result, exp_r); end
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d got=%b exp=1", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (flags_q !== 4'b0110) begin bad++; $display("FAIL stream_flags got=%b exp=0110", flags_q); end
        total++; if (out_valid !== 1'b1 || out_result !== 16'h0017) begin bad++; $display("FAIL stream_last got=%b/%h exp=1/0017", out_valid, out_result); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL midreset_flags got=%b exp=0000", flags_q); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || fwd_hit !== 1'b0) begin bad++; $display("FAIL postreset got=%b/%b exp=0/0", out_valid, fwd_hit); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_flush();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
